// File: rtl/mbgd_vec_packer.sv
// mbgd_vec_packer: collects a serial stream of (x, theta) element pairs and
// presents them to the MBGD dot-product calculator as one packed vector pair.
// Element 0 lands in the most significant slot; short vectors are zero-padded.
// Optional statistics outputs (vec_count, pad_seen) exist only when the
// macro MBGD_PACK_STATS_EN is defined.
module mbgd_vec_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ELEMS  = 8,
    parameter int N_BIT      = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_x,
    input  logic [DATA_WIDTH-1:0]           in_teta,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*NUM_ELEMS-1:0] out_x,
    output logic [DATA_WIDTH*NUM_ELEMS-1:0] out_teta,
    output logic                            enable,
    output logic [N_BIT:0]                  out_len
`ifdef MBGD_PACK_STATS_EN
    ,
    output logic [15:0]                     vec_count,
    output logic                            pad_seen
`endif
);

    localparam int W = DATA_WIDTH * NUM_ELEMS;

    typedef enum logic {S_FILL, S_WAIT} state_t;

    state_t           state_reg;
    logic [N_BIT-1:0] count_reg;
    logic [W-1:0]     asm_x_reg;
    logic [W-1:0]     asm_t_reg;
    logic [N_BIT:0]   hold_len_reg;

    logic [W-1:0]     asm_x_next;
    logic [W-1:0]     asm_t_next;
    logic [N_BIT:0]   beat_len;
    logic [N_BIT:0]   load_len;
    logic             in_xfer;
    logic             out_xfer;
    logic             closing;
    logic             load_fill;
    logic             load_wait;
    logic             stall_fill;

    // Input side is open only while no closed vector is parked internally.
    assign in_ready = (state_reg == S_FILL);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // A beat closes the vector on the last slot or on an explicit in_last.
    assign closing  = in_last || (count_reg == N_BIT'(NUM_ELEMS - 1));
    assign beat_len = {1'b0, count_reg} + {{N_BIT{1'b0}}, 1'b1};

    // Closing beat goes straight to the output when the output slot frees up
    // this cycle; otherwise the assembled pair is parked until it does.
    assign load_fill  = (state_reg == S_FILL) && in_xfer && closing && (!out_valid || out_xfer);
    assign stall_fill = (state_reg == S_FILL) && in_xfer && closing && out_valid && !out_xfer;
    assign load_wait  = (state_reg == S_WAIT) && out_xfer;
    assign load_len   = load_wait ? hold_len_reg : beat_len;

    // Assembly view including the current beat, slot by slot (slot 0 = MSB).
    generate
        for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_slot
            localparam int HI = W - 1 - gi * DATA_WIDTH;
            assign asm_x_next[HI -: DATA_WIDTH] = (in_xfer && count_reg == N_BIT'(gi))
                                                  ? in_x : asm_x_reg[HI -: DATA_WIDTH];
            assign asm_t_next[HI -: DATA_WIDTH] = (in_xfer && count_reg == N_BIT'(gi))
                                                  ? in_teta : asm_t_reg[HI -: DATA_WIDTH];
        end
    endgenerate

    // Fill/wait controller with registered output pair and enable strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FILL;
            count_reg    <= '0;
            asm_x_reg    <= '0;
            asm_t_reg    <= '0;
            hold_len_reg <= '0;
            out_valid    <= 1'b0;
            enable       <= 1'b0;
            out_x        <= '0;
            out_teta     <= '0;
            out_len      <= '0;
        end else begin
            enable <= 1'b0;
            if (out_xfer) begin
                out_valid <= 1'b0;
            end
            case (state_reg)
                S_FILL: begin
                    if (load_fill) begin
                        out_x     <= asm_x_next;
                        out_teta  <= asm_t_next;
                        out_len   <= load_len;
                        out_valid <= 1'b1;
                        enable    <= 1'b1;
                        asm_x_reg <= '0;
                        asm_t_reg <= '0;
                        count_reg <= '0;
                    end else if (stall_fill) begin
                        asm_x_reg    <= asm_x_next;
                        asm_t_reg    <= asm_t_next;
                        hold_len_reg <= beat_len;
                        count_reg    <= '0;
                        state_reg    <= S_WAIT;
                    end else if (in_xfer) begin
                        asm_x_reg <= asm_x_next;
                        asm_t_reg <= asm_t_next;
                        count_reg <= count_reg + N_BIT'(1);
                    end
                end
                S_WAIT: begin
                    if (load_wait) begin
                        out_x     <= asm_x_reg;
                        out_teta  <= asm_t_reg;
                        out_len   <= load_len;
                        out_valid <= 1'b1;
                        enable    <= 1'b1;
                        asm_x_reg <= '0;
                        asm_t_reg <= '0;
                        state_reg <= S_FILL;
                    end
                end
                default: state_reg <= S_FILL;
            endcase
        end
    end

`ifdef MBGD_PACK_STATS_EN
    // Statistics: delivered-pair counter and sticky short-vector flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_count <= '0;
            pad_seen  <= 1'b0;
        end else begin
            if (out_xfer) begin
                vec_count <= vec_count + 16'd1;
            end
            if ((load_fill || load_wait) && (load_len < (N_BIT + 1)'(NUM_ELEMS))) begin
                pad_seen <= 1'b1;
            end
        end
    end
`endif

endmodule
